// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the radix-2^BPC sequential multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int steps(input int w, input int bpc);
        return w / bpc;
    endfunction

    function automatic int cnt_w(input int w, input int bpc);
        return $clog2(w / bpc + 1);
    endfunction

    function automatic bit bpc_ok(input int w, input int bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((w % bpc) == 0);
    endfunction

endpackage

// File: rtl/mul_pp_step.sv
// One radix step: partial product a_mag*digit, aligned by cnt*BPC, added into acc.
module mul_pp_step #(
    parameter int WIDTH = 64,
    parameter int BPC   = 1,
    parameter int CNT_W = 7
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [BPC-1:0]     digit,
    input  logic [CNT_W-1:0]   cnt,
    output logic [2*WIDTH-1:0] acc_next
);

    localparam int SH_W = CNT_W + 2;

    logic [SH_W-1:0]     shamt;
    logic [2*WIDTH-1:0]  pp;

    assign shamt    = SH_W'(cnt) * SH_W'(BPC);
    // Operands are zero-extended to the product width so the multiply never truncates.
    assign pp       = {{WIDTH{1'b0}}, a_mag} * {{(2*WIDTH-BPC){1'b0}}, digit};
    assign acc_next = acc + (pp << shamt);

endmodule

// File: rtl/seq_mul_rdx.sv
// Iterative shift-and-add multiplier: BPC multiplier bits per cycle, optional signed
// operands and early exit, valid/ready on both sides.
module seq_mul_rdx
    import mul_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int BPC        = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] o
);

    localparam int STEPS = steps(WIDTH, BPC);
    localparam int CNT_W = cnt_w(WIDTH, BPC);

    if (!bpc_ok(WIDTH, BPC)) begin : g_bpc_check
        $error("seq_mul_rdx: BPC must be 1, 2 or 4 and divide WIDTH");
    end

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_shift;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last;

    assign b_shift = b_mag >> BPC;

    mul_pp_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .CNT_W (CNT_W)
    ) u_pp_step (
        .acc      (acc),
        .a_mag    (a_mag),
        .digit    (b_mag[BPC-1:0]),
        .cnt      (cnt),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Early exit looks at the post-shift multiplier so BUSY always runs once.
                last = (cnt == CNT_W'(STEPS - 1)) ||
                       ((EARLY_EXIT != 0) && ((a_mag == '0) || (b_shift == '0)));
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_mag <= '0;
            b_mag <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            o     <= '0;
        end else if (accept) begin
            // |-2^(W-1)| wraps to 2^(W-1), which is correct as an unsigned magnitude.
            a_mag <= (in_signed && a[WIDTH-1]) ? -a : a;
            b_mag <= (in_signed && b[WIDTH-1]) ? -b : b;
            neg   <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
        end else if (state == BUSY) begin
            acc   <= acc_next;
            b_mag <= b_shift;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                o <= neg ? -acc_next : acc_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_rdx.sv
// Randomised and directed bench for seq_mul_rdx across four parameterisations.
module tb_seq_mul_rdx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_ready;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        iv [4];
    logic        ir [4];
    logic        ov [4];
    logic [15:0] o_arr [4];

    int vectors     = 0;
    int miscompares = 0;

    int bpc_of [4] = '{1, 1, 2, 4};
    int ee_of  [4] = '{1, 0, 0, 0};

    always #5 clk = ~clk;

    seq_mul_rdx #(.WIDTH(8), .BPC(1), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_signed(sgn),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .o(o_arr[0]));
    seq_mul_rdx #(.WIDTH(8), .BPC(1), .EARLY_EXIT(0)) u_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_signed(sgn),
        .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .o(o_arr[1]));
    seq_mul_rdx #(.WIDTH(8), .BPC(2), .EARLY_EXIT(0)) u_b2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_signed(sgn),
        .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready), .o(o_arr[2]));
    seq_mul_rdx #(.WIDTH(8), .BPC(4), .EARLY_EXIT(0)) u_b4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_signed(sgn),
        .a(a), .b(b), .out_valid(ov[3]), .out_ready(out_ready), .o(o_arr[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y, input bit s);
        int xi;
        int yi;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        return 16'(xi * yi);
    endfunction

    function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y, input bit s,
                                   input int bpc, input int ee);
        int nsteps;
        int am;
        int bm;
        int n;
        nsteps = 8 / bpc;
        if (ee == 0) return nsteps;
        am = (s && x[7]) ? 256 - int'(x) : int'(x);
        bm = (s && y[7]) ? 256 - int'(y) : int'(y);
        if (am == 0) return 1;
        n = 1;
        while (n < nsteps && (bm >> (n * bpc)) != 0) n++;
        return n;
    endfunction

    task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y, input bit s,
                          output logic [15:0] res, output int lat, output int low);
        int n;
        n = 0;
        while (!ir[d] && n < 100) begin
            step();
            n++;
        end
        if (!ir[d]) chk("ready_timeout", 64'(ir[d]), 64'd1);
        a = x;
        b = y;
        sgn = s;
        iv[d] = 1'b1;
        step();
        iv[d] = 1'b0;
        res = '0;
        lat = 0;
        low = 0;
        for (int j = 1; j < 200; j++) begin
            if (ir[d]) break;
            low++;
            step();
            if (ov[d] && lat == 0) begin
                lat = j;
                res = o_arr[d];
            end
        end
        if (lat == 0) chk("done_timeout", 64'(ov[d]), 64'd1);
    endtask

    task automatic check_op(input int d, input logic [7:0] x, input logic [7:0] y, input bit s,
                            input string tag);
        logic [15:0] res;
        int lat;
        int low;
        run_op(d, x, y, s, res, lat, low);
        chk({tag, "_prod"}, 64'(res), 64'(ref_prod(x, y, s)));
        chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(x, y, s, bpc_of[d], ee_of[d])));
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] held;
        int lat;
        int low;
        int n;
        int d;
        logic [7:0] x;
        logic [7:0] y;
        bit s;

        for (int i = 0; i < 4; i++) iv[i] = 1'b0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        sgn = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_in_ready", 64'(ir[i]), 64'd1);
            chk("rst_out_valid", 64'(ov[i]), 64'd0);
            chk("rst_o", 64'(o_arr[i]), 64'd0);
        end

        run_op(0, 8'd13, 8'd11, 1'b0, res, lat, low);
        chk("u13x11_prod", 64'(res), 64'h008F);
        chk("u13x11_lat", 64'(lat), 64'd4);
        chk("u13x11_busy_cycles", 64'(low), 64'd5);

        run_op(0, 8'd0, 8'd255, 1'b0, res, lat, low);
        chk("a0_prod", 64'(res), 64'd0);
        chk("a0_lat", 64'(lat), 64'd1);
        run_op(0, 8'd255, 8'd0, 1'b0, res, lat, low);
        chk("b0_prod", 64'(res), 64'd0);
        chk("b0_lat", 64'(lat), 64'd1);

        run_op(0, 8'h80, 8'h80, 1'b1, res, lat, low);
        chk("s_m128sq", 64'(res), 64'h4000);
        run_op(0, 8'hFD, 8'h05, 1'b1, res, lat, low);
        chk("s_m3x5", 64'(res), 64'hFFF1);
        run_op(0, 8'h7F, 8'hFF, 1'b1, res, lat, low);
        chk("s_127xm1", 64'(res), 64'hFF81);

        // Backpressure: result must hold and new requests must be dropped.
        out_ready = 1'b0;
        a = 8'd13;
        b = 8'd11;
        sgn = 1'b0;
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 50) begin
            step();
            n++;
        end
        held = o_arr[0];
        chk("bp_result", 64'(held), 64'd143);
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            iv[0] = 1'b1;
            step();
            chk("bp_out_valid", 64'(ov[0]), 64'd1);
            chk("bp_o_stable", 64'(o_arr[0]), 64'(held));
            chk("bp_in_ready", 64'(ir[0]), 64'd0);
        end
        iv[0] = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 64'(ov[0]), 64'd0);
        chk("bp_release_ready", 64'(ir[0]), 64'd1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ov[0]) n++;
        end
        chk("bp_single_result", 64'(n), 64'd0);

        // Reset in the middle of a BUSY run.
        a = 8'd255;
        b = 8'd255;
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_out_valid", 64'(ov[0]), 64'd0);
        chk("midrst_in_ready", 64'(ir[0]), 64'd1);
        chk("midrst_o", 64'(o_arr[0]), 64'd0);
        check_op(0, 8'd7, 8'd9, 1'b0, "after_rst_7x9");
        chk("after_rst_63", 64'(ref_prod(8'd7, 8'd9, 1'b0)), 64'd63);

        run_op(1, 8'd255, 8'd255, 1'b0, res, lat, low);
        chk("nee_bpc1_prod", 64'(res), 64'd65025);
        chk("nee_bpc1_lat", 64'(lat), 64'd8);
        run_op(2, 8'd255, 8'd255, 1'b0, res, lat, low);
        chk("nee_bpc2_prod", 64'(res), 64'd65025);
        chk("nee_bpc2_lat", 64'(lat), 64'd4);
        run_op(3, 8'd255, 8'd255, 1'b0, res, lat, low);
        chk("nee_bpc4_prod", 64'(res), 64'd65025);
        chk("nee_bpc4_lat", 64'(lat), 64'd2);
        check_op(3, 8'h80, 8'h81, 1'b1, "nee_bpc4_signed");
        check_op(2, 8'hFF, 8'h80, 1'b1, "nee_bpc2_signed");

        for (int i = 0; i < 3000; i++) begin
            d = (i % 2 == 0) ? 0 : 1 + ((i / 2) % 3);
            x = 8'($urandom);
            y = 8'($urandom);
            s = bit'($urandom % 2);
            if ($urandom % 4 == 0) y = y & 8'h0F;
            if ($urandom % 16 == 0) x = 8'h00;
            if ($urandom % 16 == 0) y = 8'h80;
            check_op(d, x, y, s, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
